// File: rtl/conv2_pkg.sv
// Shared conv2 scheduler defaults and FSM encoding.
// Consumers import conv2_pkg::* so the scheduler and window counter agree on sizes.
package conv2_pkg;

    localparam int CONV2_CH_NUM     = 3;
    localparam int CONV2_OUT_WIDTH  = 8;
    localparam int CONV2_OUT_HEIGHT = 8;
    localparam int CONV2_CALC_BITS  = 14;

    // Channel index travels on 2-bit ports, so CH_NUM is capped at 4.
    localparam int CONV2_CH_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } conv2_state_t;

endpackage

// File: rtl/conv2_win_cnt.sv
// Output-window position counter: col advances per finished window, row on col wrap.
// frame_end flags the last window of a frame (col and row both at their maximum).
module conv2_win_cnt
    import conv2_pkg::*;
#(
    parameter int OUT_WIDTH  = CONV2_OUT_WIDTH,
    parameter int OUT_HEIGHT = CONV2_OUT_HEIGHT,
    localparam int COL_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1,
    localparam int ROW_W = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             frame_end
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(OUT_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(OUT_HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (advance) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col       = col_q;
    assign row       = row_q;
    assign frame_end = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/conv2_ch_sched.sv
// Time-multiplexes CH_NUM output channels of one window onto a shared conv2 datapath.
// One result per cycle into a one-deep output register; a full, unaccepted register stalls the channel walk.
module conv2_ch_sched
    import conv2_pkg::*;
#(
    parameter int CH_NUM     = CONV2_CH_NUM,
    parameter int OUT_WIDTH  = CONV2_OUT_WIDTH,
    parameter int OUT_HEIGHT = CONV2_OUT_HEIGHT,
    parameter int CALC_BITS  = CONV2_CALC_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        win_valid,
    output logic                        win_ready,
    output logic [1:0]                  calc_sel,
    input  logic signed [CALC_BITS-1:0] calc_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [CALC_BITS-1:0] out_data,
    output logic [1:0]                  out_ch,
    output logic                        out_last
);

    localparam int COL_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam int ROW_W = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
    localparam logic [CONV2_CH_W-1:0] CH_LAST = CONV2_CH_W'(CH_NUM - 1);

    conv2_state_t                state_q, state_d;
    logic [CONV2_CH_W-1:0]       ch_q, ch_d;
    logic                        out_valid_q, out_valid_d;
    logic signed [CALC_BITS-1:0] out_data_q, out_data_d;
    logic [1:0]                  out_ch_q, out_ch_d;
    logic                        out_last_q, out_last_d;

    logic             load_en;
    logic             last_ch;
    logic             frame_end;
    logic [COL_W-1:0] win_col;
    logic [ROW_W-1:0] win_row;
    logic             unused_pos;

    conv2_win_cnt #(
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_HEIGHT(OUT_HEIGHT)
    ) u_win_cnt (
        .clk      (clk),
        .rst      (rst),
        .advance  (win_ready),
        .col      (win_col),
        .row      (win_row),
        .frame_end(frame_end)
    );

    // Position is only needed as frame_end here; the raw counters are debug taps.
    assign unused_pos = ^{win_col, win_row};

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;

        load_en   = (state_q == CALC) && (!out_valid_q || out_ready);
        last_ch   = (ch_q == CH_LAST);
        win_ready = load_en && last_ch;
        calc_sel  = (state_q == CALC) ? ch_q : 2'd0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = CALC;
                    ch_d    = '0;
                end
            end
            CALC: begin
                if (load_en) begin
                    if (last_ch) begin
                        state_d = IDLE;
                        ch_d    = '0;
                    end else begin
                        ch_d = ch_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = '0;
            end
        endcase

        if (load_en) begin
            out_valid_d = 1'b1;
            out_data_d  = calc_in;
            out_ch_d    = ch_q;
            out_last_d  = last_ch && frame_end;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv2_ch_sched.sv
// Scoreboard bench for conv2_ch_sched: directed windows push expected results,
// a forked monitor pops and compares on every out_valid && out_ready handshake.
module tb_conv2_ch_sched;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              win_valid = 1'b0;
    logic              win_ready;
    logic [1:0]        calc_sel;
    logic signed [13:0] calc_in;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic signed [13:0] out_data;
    logic [1:0]        out_ch;
    logic              out_last;

    logic signed [13:0] tab0 = '0, tab1 = '0, tab2 = '0;

    typedef struct {
        logic signed [13:0] d;
        logic [1:0]         ch;
        logic               last;
        int                 cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   wr_cnt = 0;
    int   exp_wr = 0;
    int   w_idx  = 0;

    conv2_ch_sched dut (
        .clk      (clk),
        .rst      (rst),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .calc_sel (calc_sel),
        .calc_in  (calc_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_last (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the shared datapath: a per-bank constant selected by calc_sel.
    assign calc_in = (calc_sel == 2'd0) ? tab0 :
                     (calc_sel == 2'd1) ? tab1 :
                     (calc_sel == 2'd2) ? tab2 : 14'sh1555;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int d, input int ch, input bit last, input int c);
        exp_t e;
        e.d    = 14'(d);
        e.ch   = 2'(ch);
        e.last = last;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // t >= 0 pins the expected output cycles of this window (t = cycle win_valid rises).
    task automatic push_win(input int d0, input int d1, input int d2, input int t);
        bit lw;
        lw = ((w_idx % 64) == 63);
        push_exp(d0, 0, 1'b0, (t >= 0) ? t + 2 : -1);
        push_exp(d1, 1, 1'b0, (t >= 0) ? t + 3 : -1);
        push_exp(d2, 2, lw,   (t >= 0) ? t + 4 : -1);
        w_idx++;
        exp_wr++;
    endtask

    // Call at posedge+1; returns the cycle win_ready was seen, ends at posedge+1 after it.
    task automatic do_window(input bit drop_after, output int wr_cyc);
        wr_cyc    = -1;
        win_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (win_ready) begin
                wr_cyc = cyc;
                break;
            end
        end
        checks++;
        if (wr_cyc < 0) begin
            errors++;
            $display("FAIL win_ready_timeout: got no win_ready in 40 cycles, required one");
        end
        @(posedge clk);
        #1;
        if (drop_after) win_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 400; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk({name, "_drain_left"}, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int wr;

        fork
            forever begin
                @(negedge clk);
                if (win_ready) wr_cnt++;
                if (!rst && out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected: got data=%0d ch=%0d at cycle %0d, required no output",
                                 out_data, out_ch, cyc);
                    end else begin
                        automatic exp_t e = exp_q.pop_front();
                        if (out_data !== e.d || out_ch !== e.ch || out_last !== e.last ||
                            (e.cyc >= 0 && cyc != e.cyc)) begin
                            errors++;
                            $display("FAIL out_result: got data=%0d ch=%0d last=%0b cyc=%0d, required data=%0d ch=%0d last=%0b cyc=%0d",
                                     out_data, out_ch, out_last, cyc, e.d, e.ch, e.last, e.cyc);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'(out_data), 0);
        chk("rst_out_ch",    int'(out_ch), 0);
        chk("rst_out_last",  int'(out_last), 0);
        chk("rst_win_ready", int'(win_ready), 0);
        chk("rst_calc_sel",  int'(calc_sel), 0);
        rst = 1'b0;

        // Back-to-back windows: exact latency and one IDLE bubble per window
        tab0 = 14'sd5; tab1 = 14'sd15; tab2 = 14'sd25;
        @(posedge clk);
        #1;
        t = cyc;
        push_win(5, 15, 25, t);
        push_win(5, 15, 25, -1);
        do_window(1'b0, wr);
        chk("win_ready_cyc_w0", wr, t + 3);
        do_window(1'b1, wr);
        chk("win_ready_cyc_w1", wr, t + 7);
        wait_drain("b2b");
        chk("b2b_win_ready_cnt", wr_cnt, exp_wr);

        // Three-cycle stall with ch1 pending
        @(posedge clk);
        #1;
        push_win(5, 15, 25, -1);
        win_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_out_data",  int'(out_data), 15);
            chk("stall_out_ch",    int'(out_ch), 1);
            chk("stall_calc_sel",  int'(calc_sel), 2);
            chk("stall_win_ready", int'(win_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_win_ready", int'(win_ready), 1);
        @(posedge clk);
        #1;
        win_valid = 1'b0;
        wait_drain("stall");
        chk("stall_win_ready_cnt", wr_cnt, exp_wr);

        // Full-scale signed values, alternating per channel
        tab0 = -14'sd8192; tab1 = 14'sd8191; tab2 = -14'sd8192;
        push_win(-8192, 8191, -8192, -1);
        push_win(8191, -8192, 8191, -1);
        do_window(1'b0, wr);
        tab0 = 14'sd8191; tab1 = -14'sd8192; tab2 = 14'sd8191;
        do_window(1'b1, wr);
        wait_drain("extremes");

        // win_valid drops after one CALC cycle: window still completes once
        tab0 = 14'sd33; tab1 = -14'sd44; tab2 = 14'sd55;
        @(posedge clk);
        #1;
        push_win(33, -44, 55, -1);
        win_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        win_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        wait_drain("drop");
        chk("drop_win_ready_cnt", wr_cnt, exp_wr);

        // Asynchronous reset while ch1 sits in the output register
        tab0 = 14'sd1; tab1 = 14'sd2; tab2 = 14'sd3;
        @(posedge clk);
        #1;
        push_exp(1, 0, 1'b0, -1);
        win_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_out_ch", int'(out_ch), 1);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data",  int'(out_data), 0);
        chk("arst_out_ch",    int'(out_ch), 0);
        chk("arst_calc_sel",  int'(calc_sel), 0);
        win_valid = 1'b0;
        @(negedge clk);
        chk("arst_win_ready", int'(win_ready), 0);
        @(posedge clk);
        #3;
        rst   = 1'b0;
        w_idx = 0;
        chk("arst_win_ready_cnt", wr_cnt, exp_wr);

        // 64-window frame then the first window of the next frame
        tab0 = 14'sd7; tab1 = -14'sd3; tab2 = 14'sd100;
        @(posedge clk);
        #1;
        for (int i = 0; i < 65; i++) push_win(7, -3, 100, -1);
        for (int i = 0; i < 65; i++) do_window(i == 64, wr);
        wait_drain("frame");
        chk("frame_win_ready_cnt", wr_cnt, exp_wr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000, required finish");
        $fatal(1, "timeout");
    end

endmodule
